// File: rtl/l1_pkg.sv
// Constants shared by the layer-1 serializer and deserializer.
package l1_pkg;

  localparam int unsigned L1_WIDTH      = 8;
  localparam logic        L1_SLOT_LANE0 = 1'b0;
  localparam logic        L1_SLOT_LANE1 = 1'b1;

endpackage

// File: rtl/demux1_l1.sv
// Layer-1 1:2 deserializer: splits the interleaved clk_2f byte lane back into
// two paired lanes that update together once per clk_f period.
module demux1_l1
  import l1_pkg::*;
#(
  parameter int unsigned WIDTH = L1_WIDTH
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_00,
  input  logic             valid_00,
  output logic [WIDTH-1:0] data_0,
  output logic             valid_0,
  output logic [WIDTH-1:0] data_1,
  output logic             valid_1,
  output logic             phase_f
);

  logic             sel;
  logic             hold_v0;
  logic [WIDTH-1:0] hold_d0;

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      sel     <= L1_SLOT_LANE0;
      hold_v0 <= 1'b0;
      hold_d0 <= '0;
      data_0  <= '0;
      valid_0 <= 1'b0;
      data_1  <= '0;
      valid_1 <= 1'b0;
    end else begin
      sel <= ~sel;
      if (sel == L1_SLOT_LANE0) begin
        hold_v0 <= valid_00;
        if (valid_00) hold_d0 <= data_00;
      end else begin
        // Both lanes commit on the lane-1 edge so they stay aligned for a clk_f period.
        valid_0 <= hold_v0;
        if (hold_v0) data_0 <= hold_d0;
        valid_1 <= valid_00;
        if (valid_00) data_1 <= data_00;
      end
    end
  end

  assign phase_f = sel;

endmodule

// File: tb/tb_demux1_l1.sv
// Randomized self-checking bench for demux1_l1 against a slot-pairing reference model.
module tb_demux1_l1;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } slot_t;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic [7:0] data_00;
  logic       valid_00;
  logic [7:0] data_0;
  logic       valid_0;
  logic [7:0] data_1;
  logic       valid_1;
  logic       phase_f;

  int unsigned errors = 0;
  int unsigned checks = 0;

  slot_t      slots[$];
  logic [7:0] exp_d0, exp_d1;
  logic       exp_v0, exp_v1;
  logic [7:0] lane0_q[$];
  logic [7:0] lane1_q[$];
  logic       track_lanes = 1'b0;

  demux1_l1 #(.WIDTH(8)) dut (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .data_00 (data_00),
    .valid_00(valid_00),
    .data_0  (data_0),
    .valid_0 (valid_0),
    .data_1  (data_1),
    .valid_1 (valid_1),
    .phase_f (phase_f)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("phase_f", {31'd0, phase_f}, {31'd0, slots.size() == 1});
    check("valid_0", {31'd0, valid_0}, {31'd0, exp_v0});
    check("valid_1", {31'd0, valid_1}, {31'd0, exp_v1});
    check("data_0", {24'd0, data_0}, {24'd0, exp_d0});
    check("data_1", {24'd0, data_1}, {24'd0, exp_d1});
  endtask

  // Present one slot, advance one clk_2f edge, update the model, then check at negedge.
  task automatic step(input logic rst, input logic v, input logic [7:0] d);
    slot_t s0, s1;
    reset    = rst;
    valid_00 = v;
    data_00  = d;
    @(posedge clk_2f);
    if (rst) begin
      slots.delete();
      exp_d0 = '0; exp_d1 = '0; exp_v0 = 1'b0; exp_v1 = 1'b0;
    end else begin
      slots.push_back('{v: v, d: d});
      if (track_lanes && v) begin
        if (slots.size() == 1) lane0_q.push_back(d);
        else                   lane1_q.push_back(d);
      end
      if (slots.size() == 2) begin
        s0 = slots.pop_front();
        s1 = slots.pop_front();
        exp_v0 = s0.v;
        exp_v1 = s1.v;
        if (s0.v) exp_d0 = s0.d;
        if (s1.v) exp_d1 = s1.d;
      end
    end
    @(negedge clk_2f);
    check_all();
  endtask

  initial begin
    slots.delete();
    exp_d0 = '0; exp_d1 = '0; exp_v0 = 1'b0; exp_v1 = 1'b0;

    // Reset with active-looking input
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    // Continuous stream
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b1, 8'h44);
    check("stream_d0", {24'd0, data_0}, 32'h33);
    check("stream_d1", {24'd0, data_1}, 32'h44);
    // Invalid lane 0
    step(1'b0, 1'b0, 8'hAA);
    step(1'b0, 1'b1, 8'h55);
    check("inv0_d0", {24'd0, data_0}, 32'h33);
    check("inv0_d1", {24'd0, data_1}, 32'h55);
    check("inv0_v0", {31'd0, valid_0}, 32'h0);
    // Idle pair
    step(1'b0, 1'b0, 8'h12);
    step(1'b0, 1'b0, 8'h34);
    // Reset on commit edge discards a captured lane-0 byte
    step(1'b0, 1'b1, 8'h77);
    step(1'b1, 1'b1, 8'h99);
    check("midrst_d0", {24'd0, data_0}, 32'h0);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h02);
    check("after_rst_d0", {24'd0, data_0}, 32'h01);
    check("after_rst_d1", {24'd0, data_1}, 32'h02);

    // Random phase with occasional resets
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom), 8'($urandom));

    // Loopback: both lanes must reproduce their streams in order
    step(1'b1, 1'b0, 8'h00);
    track_lanes = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      for (int k = 0; k < 2; k++) begin
        step(1'b0, 1'($urandom), 8'($urandom));
        if (k == 1) begin
          if (valid_0) begin
            if (lane0_q.size() == 0) check("lane0_underflow", 32'd1, 32'd0);
            else check("lane0_order", {24'd0, data_0}, {24'd0, lane0_q.pop_front()});
          end
          if (valid_1) begin
            if (lane1_q.size() == 0) check("lane1_underflow", 32'd1, 32'd0);
            else check("lane1_order", {24'd0, data_1}, {24'd0, lane1_q.pop_front()});
          end
        end
      end
    end
    check("lane0_drained", lane0_q.size(), 32'd0);
    check("lane1_drained", lane1_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux1_l1.md
# demux1_l1

Layer-1 1:2 demultiplexer that deserializes the single interleaved byte lane `data_00`/`valid_00`, clocked at `clk_2f`, back into two parallel lanes `data_0`/`data_1`. Even slots carry lane 0 and odd slots carry lane 1. The block sits at the receive end of the layer-1 serializer link. It re-pairs both lanes so that they update together and stay stable for two `clk_2f` cycles, which is one downstream `clk_f` period. An internal phase toggle sets the slot alignment, so the upstream serializer must leave reset on the same `clk_2f` edge.

## Interface
- `WIDTH`, default 8: lane data width in bits.
- `clk_2f`, input, 1: double-rate clock. All logic is clocked on the rising edge.
- `reset`, input, 1: synchronous reset, active-high.
- `data_00`, input, `WIDTH`: serialized data. Slot 0 carries lane 0 and slot 1 carries lane 1.
- `valid_00`, input, 1: qualifies `data_00` in the current slot.
- `data_0`, output, `WIDTH`: lane 0 data, registered.
- `valid_0`, output, 1: lane 0 valid, registered.
- `data_1`, output, `WIDTH`: lane 1 data, registered.
- `valid_1`, output, 1: lane 1 valid, registered.
- `phase_f`, output, 1: current slot selector. It is 0 during the lane-0 slot and 1 during the lane-1 slot, and downstream logic may use it as a `clk_f`-rate enable.

## Operation
- **Slot selector `sel`.**
  - `reset` forces `sel` to 0.
  - Otherwise `sel` toggles on every `clk_2f` edge.
  - `phase_f` = `sel`.
- **`sel`=0 edge (lane-0 slot): capture.**
  - `hold_v0` <= `valid_00`.
  - If `valid_00`=1: `hold_d0` <= `data_00`. If `valid_00`=0: `hold_d0` is unchanged.
  - Outputs do not change on this edge.
- **`sel`=1 edge (lane-1 slot): pair commit.**
  - `valid_0` <= `hold_v0`.
  - `data_0` <= `hold_d0` if `hold_v0`=1; otherwise `data_0` is unchanged.
  - `valid_1` <= `valid_00`.
  - `data_1` <= `data_00` if `valid_00`=1; otherwise `data_1` is unchanged.
- **Hold-on-invalid.** A data output only changes when its lane's byte is valid. Its valid output is rewritten at every commit edge, so a valid flag is high for exactly the 2 cycles following a commit that carried valid data.
- **Independent lanes.** A valid lane-1 byte commits even when the preceding lane-0 slot was invalid, and the reverse also holds.
- **No flow control.** There is no backpressure and no ready signal. Every slot is consumed.

## Timing
- **Reset values.** `sel`=0, `hold_v0`=0, `hold_d0`=0, `data_0`=0, `data_1`=0, `valid_0`=0, `valid_1`=0, `phase_f`=0.
- **First slot.** The first edge after `reset` deasserts is a lane-0 capture edge.
- **Lane-0 latency.** A byte sampled at lane-0 edge E is visible on `data_0` after edge E+1, i.e. 2 edges after it was presented.
- **Lane-1 latency.** A byte sampled at lane-1 edge E+1 is visible on `data_1` after edge E+1, i.e. 1 edge.
- **Output stability.** All four data/valid outputs change only after `sel`=1 edges. They are stable across the following `sel`=0 edge, for a 2-cycle window.
- **Reset mid-pair.** If `reset` is asserted on a commit edge, the reset wins. A captured lane-0 byte is discarded, all outputs clear, and the next edge is again a lane-0 capture.
- **Continuous traffic.** Continuous valid input gives 100% throughput: one lane pair per 2 cycles, with no bubbles.
- **Selector wrap.** `sel` wraps 1→0 freely, with no counter saturation.

## Structure
- **Shared package (`l1_pkg`).**
  - `L1_WIDTH` = 8.
  - `L1_SLOT_LANE0` = 1'b0 and `L1_SLOT_LANE1` = 1'b1.
  - The same constants are used by the serializer.
- **Single module, no sub-modules.** The phase toggle is one flop and does not justify its own module.

## Test plan
1. **Reset.** Assert `reset` for 2 cycles with `valid_00`=1 and `data_00`=8'hFF → all outputs and `phase_f` are 0 throughout. On the first edge after release, `phase_f` becomes 1 and the outputs are still 0.
2. **Continuous stream.** Slots carry 8'h11, 8'h22, 8'h33, 8'h44 with `valid_00` high → after the 2nd edge, `data_0`=8'h11, `data_1`=8'h22, both valids are 1, held for 2 cycles. After the 4th edge, `data_0`=8'h33 and `data_1`=8'h44.
3. **Invalid lane 0.** Lane-0 slot has `valid_00`=0 with `data_00`=8'hAA; lane-1 slot has `valid_00`=1 with `data_00`=8'h55 → `valid_0`=0, `data_0` keeps its previous value (8'h33 after scenario 2), `data_1`=8'h55, `valid_1`=1.
4. **Idle pair.** Both slots invalid → `valid_0`=0 and `valid_1`=0, and both data outputs hold their last values.
5. **Reset mid-pair.** Capture 8'h77 in a lane-0 slot, then assert `reset` on the following commit edge → outputs are 0 and 8'h77 never appears. The next valid pair 8'h01/8'h02 commits correctly 2 edges after release.
6. **Loopback.** Serializer and `demux1_l1` are reset together, with random valid patterns on both lanes → each lane reproduces its input stream in order, with no lane swap, over 1000 pairs.
